pc_stack_counter: RTL and testbench

Parametrised program counter for the 8-bit CPU, the successor to the fixed 4-bit JK-based PC. It provides a WIDTH-bit counter with synchronous clear, load, increment and bus drive, plus a DEPTH-entry hardware return-address stack for CALL/RET. It sits between the control sequencer (control strobes) and the shared W-bus (address in/out).

---
 rtl/pc_stack_counter_pkg.sv | 22 ++
 rtl/pc_stack_counter_if.sv | 39 +++
 rtl/pc_stack_counter_return_stack.sv | 52 +++++
 rtl/pc_stack_counter.sv | 112 +++++++++++
 tb/tb_pc_stack_counter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_stack_counter_pkg.sv
// Shared types and helpers for the program counter and its return-address stack.
// PC_REL_BRANCH_EN selects the relative-jump action; the enum always carries PC_JR.
package pc_pkg;

   typedef enum logic [2:0] {
      PC_HOLD,
      PC_CLR,
      PC_LOAD,
      PC_JR,
      PC_RET,
      PC_CALL,
      PC_INC
   } pc_action_t;

   localparam int unsigned PcResetVal = 0;

   // One extra bit so that "DEPTH entries held" is representable.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/pc_stack_counter_if.sv
// Sequencer <-> PC strobe/bus bundle. Build with PC_REL_BRANCH_EN to add the jr strobe.
interface pc_stack_counter_if #(
   parameter int unsigned WIDTH = 8
);
   logic             clr_n;
   logic             lp;
   logic             cp;
   logic             ep;
   logic             call;
   logic             ret;
`ifdef PC_REL_BRANCH_EN
   logic             jr;
`endif
   logic [WIDTH-1:0] bus_in;
   logic [WIDTH-1:0] bus_out;
   logic             bus_oe;
   logic [WIDTH-1:0] pc_q;
   logic             stack_full;
   logic             stack_empty;
   logic             stack_err;
   logic             wrap;

   modport master (
`ifdef PC_REL_BRANCH_EN
      output jr,
`endif
      output clr_n, lp, cp, ep, call, ret, bus_in,
      input  bus_out, bus_oe, pc_q, stack_full, stack_empty, stack_err, wrap
   );

   modport slave (
`ifdef PC_REL_BRANCH_EN
      input  jr,
`endif
      input  clr_n, lp, cp, ep, call, ret, bus_in,
      output bus_out, bus_oe, pc_q, stack_full, stack_empty, stack_err, wrap
   );

endinterface

// File: rtl/pc_stack_counter_return_stack.sv
// DEPTH-entry LIFO of return addresses with synchronous clear and async reset.
module pc_return_stack
   import pc_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PtrW = ptr_width(DEPTH);
   localparam int unsigned IdxW = PtrW - 1;

   logic [PtrW-1:0]  ptr_q, ptr_d;
   logic [IdxW-1:0]  wr_idx, top_idx;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign full    = (ptr_q == PtrW'(DEPTH));
   assign empty   = (ptr_q == '0);
   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;
   assign wr_idx  = ptr_q[IdxW-1:0];
   assign top_idx = IdxW'(ptr_q - PtrW'(1));
   assign dout    = mem_q[top_idx];

   always_comb begin
      ptr_d = ptr_q;
      if (clear)        ptr_d = '0;
      else if (do_push) ptr_d = ptr_q + PtrW'(1);
      else if (do_pop)  ptr_d = ptr_q - PtrW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

   // Entries need no reset: the pointer alone defines what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_idx] <= din;
   end

endmodule

// File: rtl/pc_stack_counter.sv
// WIDTH-bit program counter with CALL/RET return stack and combinational bus drive.
// Define PC_REL_BRANCH_EN to add the jr (pc += signed bus_in) action.
module pc_stack_counter
   import pc_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input logic               clk,
   input logic               rst_n,
   pc_stack_counter_if.slave bus
);

   pc_action_t       action;
   logic [WIDTH-1:0] count_q, count_d;
   logic             err_q, err_d;
   logic             wrap_q, wrap_d;
   logic             stk_clear, stk_push, stk_pop;
   logic [WIDTH-1:0] stk_top;
   logic             stk_full, stk_empty;

   pc_return_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (stk_clear),
      .push  (stk_push),
      .pop   (stk_pop),
      .din   (count_q),
      .dout  (stk_top),
      .full  (stk_full),
      .empty (stk_empty)
   );

   // Exactly one action per cycle; lower-priority strobes are dropped.
   always_comb begin
      action = PC_HOLD;
      if (!bus.clr_n)   action = PC_CLR;
      else if (bus.lp)  action = PC_LOAD;
`ifdef PC_REL_BRANCH_EN
      else if (bus.jr)  action = PC_JR;
`endif
      else if (bus.ret) action = PC_RET;
      else if (bus.call) action = PC_CALL;
      else if (bus.cp)  action = PC_INC;
   end

   always_comb begin
      count_d   = count_q;
      err_d     = err_q;
      wrap_d    = 1'b0;
      stk_clear = 1'b0;
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      unique case (action)
         PC_CLR: begin
            count_d   = WIDTH'(PcResetVal);
            err_d     = 1'b0;
            stk_clear = 1'b1;
         end
         PC_LOAD: count_d = bus.bus_in;
`ifdef PC_REL_BRANCH_EN
         // Same-width add is the modulo sign-extended offset.
         PC_JR:   count_d = count_q + bus.bus_in;
`endif
         PC_RET: begin
            if (stk_empty) begin
               err_d = 1'b1;
            end else begin
               count_d = stk_top;
               stk_pop = 1'b1;
            end
         end
         PC_CALL: begin
            if (stk_full) begin
               err_d = 1'b1;
            end else begin
               count_d  = bus.bus_in;
               stk_push = 1'b1;
            end
         end
         PC_INC: begin
            count_d = count_q + WIDTH'(1);
            wrap_d  = &count_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= WIDTH'(PcResetVal);
         err_q   <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         err_q   <= err_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.pc_q        = count_q;
   assign bus.bus_oe      = bus.ep;
   assign bus.bus_out     = bus.ep ? count_q : '0;
   assign bus.stack_full  = stk_full;
   assign bus.stack_empty = stk_empty;
   assign bus.stack_err   = err_q;
   assign bus.wrap        = wrap_q;

endmodule

// File: tb/tb_pc_stack_counter.sv
// Directed + randomized bench for pc_stack_counter against a queue-based reference model.
module tb_pc_stack_counter;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;

   logic clk;
   logic rst_n;

   pc_stack_counter_if #(.WIDTH(WIDTH)) ifc ();

   pc_stack_counter #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   // Reference model state
   int unsigned m_pc;
   int unsigned m_stk[$];
   bit          m_err;
   bit          m_wrap;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 0;
      m_stk.delete();
      m_err = 0;
      m_wrap = 0;
   endtask

   task automatic model_step();
      int unsigned nxt;
      nxt    = m_pc;
      m_wrap = 0;
      if (!ifc.clr_n) begin
         nxt = 0;
         m_stk.delete();
         m_err = 0;
      end else if (ifc.lp) begin
         nxt = ifc.bus_in;
`ifdef PC_REL_BRANCH_EN
      end else if (ifc.jr) begin
         nxt = int'(unsigned'(int'(m_pc) + int'($signed(ifc.bus_in)))) % 256;
`endif
      end else if (ifc.ret) begin
         if (m_stk.size() == 0) m_err = 1;
         else nxt = m_stk.pop_back();
      end else if (ifc.call) begin
         if (m_stk.size() == DEPTH) m_err = 1;
         else begin
            m_stk.push_back(m_pc);
            nxt = ifc.bus_in;
         end
      end else if (ifc.cp) begin
         nxt    = (m_pc + 1) % 256;
         m_wrap = (m_pc == 255);
      end
      m_pc = nxt;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pc"}, 32'(ifc.pc_q), m_pc);
      chk({tag, ".full"}, 32'(ifc.stack_full), 32'(m_stk.size() == DEPTH));
      chk({tag, ".empty"}, 32'(ifc.stack_empty), 32'(m_stk.size() == 0));
      chk({tag, ".err"}, 32'(ifc.stack_err), 32'(m_err));
      chk({tag, ".wrap"}, 32'(ifc.wrap), 32'(m_wrap));
      chk({tag, ".oe"}, 32'(ifc.bus_oe), 32'(ifc.ep));
      chk({tag, ".bus"}, 32'(ifc.bus_out), ifc.ep ? m_pc : 0);
   endtask

   task automatic idle();
      ifc.clr_n = 1; ifc.lp = 0; ifc.cp = 0; ifc.ep = 0;
      ifc.call = 0; ifc.ret = 0; ifc.bus_in = '0;
`ifdef PC_REL_BRANCH_EN
      ifc.jr = 0;
`endif
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   initial begin
      rst_n = 0;
      idle();
      model_reset();
      #12 rst_n = 1;
      #1 check_all("reset");

      // Three increments, then combinational bus drive
      ifc.cp = 1;
      repeat (3) tick("inc");
      chk("pc_eq3", 32'(ifc.pc_q), 32'h03);
      idle();
      ifc.ep = 1;
      #1 chk("bus_ep1", 32'(ifc.bus_out), 32'h03);
      chk("oe_ep1", 32'(ifc.bus_oe), 32'h1);
      ifc.ep = 0;
      #1 chk("bus_ep0", 32'(ifc.bus_out), 32'h00);

      // Load then roll over
      ifc.lp = 1; ifc.bus_in = 8'hFE; tick("load");
      idle(); ifc.cp = 1; tick("to_ff");
      chk("pc_ff", 32'(ifc.pc_q), 32'hFF);
      tick("rollover");
      chk("wrap_set", 32'(ifc.wrap), 32'h1);
      idle(); tick("wrap_clear");
      chk("wrap_one_cycle", 32'(ifc.wrap), 32'h0);

      // Single call / ret
      ifc.lp = 1; ifc.bus_in = 8'h10; tick("load10");
      idle(); ifc.call = 1; ifc.bus_in = 8'h80; tick("call");
      chk("call_target", 32'(ifc.pc_q), 32'h80);
      idle(); ifc.ret = 1; tick("ret");
      chk("ret_addr", 32'(ifc.pc_q), 32'h10);
      chk("ret_empty", 32'(ifc.stack_empty), 32'h1);

      // Fill, overflow, drain, underflow
      for (int i = 0; i < 4; i++) begin
         idle(); ifc.call = 1; ifc.bus_in = 8'(8'h20 + i); tick("fill");
      end
      chk("full_after4", 32'(ifc.stack_full), 32'h1);
      idle(); ifc.call = 1; ifc.bus_in = 8'h55; tick("overflow");
      chk("ovf_pc", 32'(ifc.pc_q), 32'h23);
      chk("ovf_err", 32'(ifc.stack_err), 32'h1);
      idle(); ifc.ret = 1;
      tick("pop0"); chk("lifo0", 32'(ifc.pc_q), 32'h22);
      tick("pop1"); chk("lifo1", 32'(ifc.pc_q), 32'h21);
      tick("pop2"); chk("lifo2", 32'(ifc.pc_q), 32'h20);
      tick("pop3"); chk("lifo3", 32'(ifc.pc_q), 32'h10);
      tick("underflow");
      chk("udf_pc", 32'(ifc.pc_q), 32'h10);
      chk("udf_err", 32'(ifc.stack_err), 32'h1);

      // Priority: lp beats cp and call; clear beats everything
      idle(); ifc.lp = 1; ifc.cp = 1; ifc.call = 1; ifc.bus_in = 8'h20; tick("prio");
      chk("prio_pc", 32'(ifc.pc_q), 32'h20);
      chk("prio_stack", 32'(ifc.stack_empty), 32'h1);
      idle(); ifc.call = 1; ifc.bus_in = 8'h40; tick("precall");
      idle(); ifc.clr_n = 0; ifc.lp = 1; ifc.bus_in = 8'h77; tick("clear");
      chk("clr_pc", 32'(ifc.pc_q), 32'h0);
      chk("clr_err", 32'(ifc.stack_err), 32'h0);

`ifdef PC_REL_BRANCH_EN
      idle(); ifc.lp = 1; ifc.bus_in = 8'h10; tick("jr_load");
      idle(); ifc.jr = 1; ifc.ret = 1; ifc.bus_in = 8'hFC; tick("jr");
      chk("jr_pc", 32'(ifc.pc_q), 32'h0C);
`endif

      // Async reset in the middle of a call
      idle(); ifc.call = 1; ifc.bus_in = 8'h33; tick("pre_rst");
      ifc.bus_in = 8'h44;
      @(negedge clk);
      rst_n = 0;
      model_reset();
      #1 check_all("async_rst");
      #1 rst_n = 1;
      idle();
      #1 check_all("post_rst");

      // Randomized strobes against the model
      for (int n = 0; n < 400; n++) begin
         ifc.clr_n  = ($urandom_range(0, 15) != 0);
         ifc.lp     = ($urandom_range(0, 5) == 0);
         ifc.ret    = ($urandom_range(0, 3) == 0);
         ifc.call   = ($urandom_range(0, 2) == 0);
         ifc.cp     = $urandom_range(0, 1) == 1;
         ifc.ep     = $urandom_range(0, 1) == 1;
         ifc.bus_in = 8'($urandom);
`ifdef PC_REL_BRANCH_EN
         ifc.jr     = ($urandom_range(0, 5) == 0);
`endif
         tick("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
